hex_display_scan: RTL and testbench



---
 rtl/hex_display_pkg.sv | 15 +
 rtl/hex_seg_decode.sv | 13 +
 rtl/hex_display_scan.sv | 214 +++++++++++++++++++++
 tb/tb_hex_display_scan.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: segment patterns and FSM states.
package hex_display_pkg;

    localparam int SEG_W = 7;

    // Active-high patterns, bit 0 = top ... bit 6 = middle; inverted where driven.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [15:0][SEG_W-1:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,   // F..8
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F    // 7..0
    };

    typedef enum logic [1:0] {IDLE, WALK, COMMIT} state_e;

endpackage

// File: rtl/hex_seg_decode.sv
// Nibble to active-low seven-segment pattern, with forced blank.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_n
);

    // Blank wins over the nibble value.
    always_comb seg_n = blank ? ~SEG_BLANK : ~SEG_HEX[nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Multi-digit hex display controller: handshake load, leading-zero walk, atomic commit,
// static per-digit outputs and a time-multiplexed scanned bus.
// Optional blink support is built when HEX_BLINK_EN is defined.
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [4*NUM_DIGITS-1:0]     load_value,
    input  logic                        load_blank_lz,
    input  logic [NUM_DIGITS-1:0]       load_dp_mask,
    input  logic [NUM_DIGITS-1:0]       load_blink_mask,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_n,
    output logic [SEG_W-1:0]            seg_n,
    output logic                        dp_n,
    output logic [NUM_DIGITS-1:0]       dig_en_n
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                walk_idx_q, walk_idx_d;
    logic                            supp_q, supp_d;
    logic                            load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0][3:0]      sh_val_q, sh_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]           sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_n_q, hex_n_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [IDX_W-1:0]                scan_idx_q, scan_idx_d;
    logic [SEG_W-1:0]                seg_n_q, seg_n_d, scan_seg;
    logic                            dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]           dig_en_n_q, dig_en_n_d;
    logic                            accept, commit;
    logic [NUM_DIGITS-1:0]           blink_off_now, blink_off_nxt;

    assign accept = (state_q == IDLE) && load_valid && load_ready_q;
    assign commit = (state_q == COMMIT);

    // Load FSM: capture into shadow, walk digits MSB-first deciding blanks, then commit.
    always_comb begin
        state_d      = state_q;
        walk_idx_d   = walk_idx_q;
        supp_d       = supp_q;
        sh_val_d     = sh_val_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_val_d   = load_value;
                    sh_dp_d    = load_dp_mask;
                    walk_idx_d = IDX_LAST;
                    supp_d     = load_blank_lz;
                    state_d    = WALK;
                end
            end
            WALK: begin
                // Digit 0 is never suppressed so an all-zero value still shows "0".
                if (supp_q && (walk_idx_q != '0) && (sh_val_q[walk_idx_q] == 4'h0)) begin
                    sh_blank_d[walk_idx_q] = 1'b1;
                end else begin
                    sh_blank_d[walk_idx_q] = 1'b0;
                    supp_d                 = 1'b0;
                end
                if (walk_idx_q == '0) state_d = COMMIT;
                else                  walk_idx_d = walk_idx_q - 1'b1;
            end
            COMMIT: begin
                disp_val_d   = sh_val_q;
                disp_dp_d    = sh_dp_q;
                disp_blank_d = sh_blank_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        load_ready_d = (state_d == IDLE);
    end

    // FSM, shadow and display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            walk_idx_q   <= '0;
            supp_q       <= 1'b0;
            load_ready_q <= 1'b0;
            sh_val_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
        end else begin
            state_q      <= state_d;
            walk_idx_q   <= walk_idx_d;
            supp_q       <= supp_d;
            load_ready_q <= load_ready_d;
            sh_val_q     <= sh_val_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
        end
    end

`ifdef HEX_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, disp_blink_q, disp_blink_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  phase_q, phase_d;

    // Blink mask follows the same capture/commit path; phase toggles every BLINK_DIV clocks.
    always_comb begin
        sh_blink_d   = accept ? load_blink_mask : sh_blink_q;
        disp_blink_d = commit ? sh_blink_q : disp_blink_q;
        blk_cnt_d    = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + 1'b1;
        phase_d      = (blk_cnt_q == BLK_LAST) ? ~phase_q : phase_q;
    end

    // Blink state registers; phase starts "on".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_blink_q   <= '0;
            disp_blink_q <= '0;
            blk_cnt_q    <= '0;
            phase_q      <= 1'b1;
        end else begin
            sh_blink_q   <= sh_blink_d;
            disp_blink_q <= disp_blink_d;
            blk_cnt_q    <= blk_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign blink_off_now = disp_blink_q & {NUM_DIGITS{~phase_q}};
    assign blink_off_nxt = disp_blink_d & {NUM_DIGITS{~phase_d}};
`else
    logic unused_blink;
    assign unused_blink  = ^{load_blink_mask, 32'(BLINK_DIV)};
    assign blink_off_now = '0;
    assign blink_off_nxt = '0;
`endif

    // Static outputs decode the next display state so they land with the commit edge.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        hex_seg_decode u_dec (
            .nibble (disp_val_d[i]),
            .blank  (disp_blank_d[i] | blink_off_nxt[i]),
            .seg_n  (hex_n_d[i])
        );
    end

    hex_seg_decode u_scan_dec (
        .nibble (disp_val_q[scan_idx_q]),
        .blank  (disp_blank_q[scan_idx_q] | blink_off_now[scan_idx_q]),
        .seg_n  (scan_seg)
    );

    // Free-running scan: count 0 of each slot is an all-off anti-ghosting cycle.
    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (div_q == DIV_LAST) scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        seg_n_d    = '1;
        dp_n_d     = 1'b1;
        dig_en_n_d = '1;
        if (div_q != '0) begin
            dig_en_n_d = ~(NUM_DIGITS'(1) << scan_idx_q);
            seg_n_d    = scan_seg;
            dp_n_d     = ~(disp_dp_q[scan_idx_q] & ~blink_off_now[scan_idx_q]);
        end
    end

    // Output and scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_n_q    <= '1;
            div_q      <= '0;
            scan_idx_q <= '0;
            seg_n_q    <= '1;
            dp_n_q     <= 1'b1;
            dig_en_n_q <= '1;
        end else begin
            hex_n_q    <= hex_n_d;
            div_q      <= div_d;
            scan_idx_q <= scan_idx_d;
            seg_n_q    <= seg_n_d;
            dp_n_q     <= dp_n_d;
            dig_en_n_q <= dig_en_n_d;
        end
    end

    assign load_ready = load_ready_q;
    assign hex_n      = hex_n_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign dig_en_n   = dig_en_n_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan (4 digits, SCAN_DIV=4, BLINK_DIV=8).
module tb_hex_display_scan;

    localparam logic [27:0] BLANK_ALL = 28'hFFFFFFF;
    localparam logic [27:0] EXP_1234  = {~7'h06, ~7'h5B, ~7'h4F, ~7'h66};
    localparam logic [27:0] EXP_0050  = {7'h7F, 7'h7F, ~7'h6D, ~7'h3F};
    localparam logic [27:0] EXP_0000  = {7'h7F, 7'h7F, 7'h7F, ~7'h3F};
    localparam logic [27:0] EXP_0105  = {7'h7F, ~7'h06, ~7'h3F, ~7'h6D};
    localparam logic [27:0] EXP_ABCD  = {~7'h77, ~7'h7C, ~7'h39, ~7'h5E};
    localparam logic [27:0] EXP_9876  = {~7'h6F, ~7'h7F, ~7'h07, ~7'h7D};
    localparam logic [27:0] EXP_4321  = {~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
    localparam logic [6:0]  SEG_D_N   = ~7'h5E;
    localparam logic [6:0]  SEG_C_N   = ~7'h39;
    localparam logic [6:0]  SEG_3_N   = ~7'h4F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic        load_blank_lz;
    logic [3:0]  load_dp_mask;
    logic [3:0]  load_blink_mask;
    logic [27:0] hex_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_en_n;

    int          errors = 0;
    int          checks = 0;
    logic [27:0] cur_exp;

    hex_display_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_value      (load_value),
        .load_blank_lz   (load_blank_lz),
        .load_dp_mask    (load_dp_mask),
        .load_blink_mask (load_blink_mask),
        .hex_n           (hex_n),
        .seg_n           (seg_n),
        .dp_n            (dp_n),
        .dig_en_n        (dig_en_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Handshake one value, scramble inputs after capture, verify latency and result.
    task automatic load_chk(input string tag, input logic [15:0] v, input logic blz,
                            input logic [3:0] dp, input logic [3:0] bl,
                            input logic [27:0] exp, input bit chk_hex);
        for (int i = 0; i < 50 && !load_ready; i++) tick();
        check({tag, "_rdy_wait"}, 32'(load_ready), 32'd1);
        load_value = v; load_blank_lz = blz; load_dp_mask = dp; load_blink_mask = bl;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        load_value = ~v; load_blank_lz = ~blz; load_dp_mask = ~dp; load_blink_mask = ~bl;
        for (int k = 1; k <= 5; k++) begin
            check({tag, "_busy"}, 32'(load_ready), 32'd0);
            if (k == 5 && chk_hex) check({tag, "_old"}, 32'(hex_n), 32'(cur_exp));
            tick();
        end
        check({tag, "_rdy_back"}, 32'(load_ready), 32'd1);
        if (chk_hex) check({tag, "_hex"}, 32'(hex_n), 32'(exp));
        cur_exp = exp;
    endtask

    logic [3:0] prev_en;
    bit         found;
    logic [3:0] exp_en [9];
    logic [6:0] samp [24];

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_value = '0;
        load_blank_lz = 1'b0; load_dp_mask = '0; load_blink_mask = '0;
        cur_exp = BLANK_ALL;

        // Reset state
        repeat (3) tick();
        check("rst_hex", 32'(hex_n), 32'(BLANK_ALL));
        check("rst_en", 32'(dig_en_n), 32'hF);
        check("rst_rdy", 32'(load_ready), 32'd0);
        check("rst_seg", 32'({seg_n, dp_n}), 32'hFF);
        rst_n = 1'b1;
        check("rel_rdy0", 32'(load_ready), 32'd0);
        tick();
        check("rel_rdy1", 32'(load_ready), 32'd1);

        // Plain loads and leading-zero suppression
        load_chk("l1234", 16'h1234, 1'b0, 4'b0000, 4'b0000, EXP_1234, 1'b1);
        load_chk("l0050", 16'h0050, 1'b1, 4'b0000, 4'b0000, EXP_0050, 1'b1);
        load_chk("l0000", 16'h0000, 1'b1, 4'b0000, 4'b0000, EXP_0000, 1'b1);
        load_chk("l0105", 16'h0105, 1'b1, 4'b0000, 4'b0000, EXP_0105, 1'b1);
        load_chk("lABCD", 16'hABCD, 1'b0, 4'b0001, 4'b0000, EXP_ABCD, 1'b1);

        // Scan sequence: sync on start of digit 0 slot
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_en = dig_en_n;
            tick();
            if (prev_en == 4'b1111 && dig_en_n == 4'b1110) found = 1'b1;
        end
        check("scan_sync", 32'(found), 32'd1);
        exp_en = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1011};
        for (int k = 0; k < 9; k++) begin
            check("scan_en", 32'(dig_en_n), 32'(exp_en[k]));
            if (k < 3) check("scan_d0", 32'({seg_n, dp_n}), 32'({SEG_D_N, 1'b0}));
            if (k >= 4 && k <= 6) check("scan_d1", 32'({seg_n, dp_n}), 32'({SEG_C_N, 1'b1}));
            tick();
        end

        // Back-to-back: valid held with a new value during the walk
        for (int i = 0; i < 50 && !load_ready; i++) tick();
        load_value = 16'h9876; load_blank_lz = 1'b0; load_dp_mask = '0; load_valid = 1'b1;
        tick();
        load_value = 16'h4321;
        for (int k = 1; k <= 5; k++) begin
            check("b2b_busy", 32'(load_ready), 32'd0);
            tick();
        end
        check("b2b_rdy", 32'(load_ready), 32'd1);
        check("b2b_first", 32'(hex_n), 32'(EXP_9876));
        tick();
        load_valid = 1'b0;
        check("b2b_acc", 32'(load_ready), 32'd0);
        repeat (4) tick();
        check("b2b_hold", 32'(hex_n), 32'(EXP_9876));
        tick();
        check("b2b_second", 32'(hex_n), 32'(EXP_4321));

        // Reset mid-walk discards the pending load
        load_value = 16'hFFFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_hex", 32'(hex_n), 32'(BLANK_ALL));
        check("mrst_en", 32'(dig_en_n), 32'hF);
        check("mrst_rdy", 32'(load_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mrst_nocommit", 32'(hex_n), 32'(BLANK_ALL));
        check("mrst_rdy1", 32'(load_ready), 32'd1);
        cur_exp = BLANK_ALL;

        // Blink on digit 1
        load_chk("lblink", 16'h1234, 1'b0, 4'b0000, 4'b0010, EXP_1234, 1'b0);
        for (int k = 0; k < 24; k++) begin
            samp[k] = hex_n[13:7];
            check("blink_others", 32'({hex_n[27:14], hex_n[6:0]}),
                  32'({EXP_1234[27:14], EXP_1234[6:0]}));
            tick();
        end
`ifdef HEX_BLINK_EN
        for (int k = 0; k < 16; k++) begin
            check("blink_val", 32'(samp[k] == SEG_3_N || samp[k] == 7'h7F), 32'd1);
            check("blink_toggle", 32'(samp[k + 8] != samp[k]), 32'd1);
        end
`else
        for (int k = 0; k < 24; k++) check("noblink_d1", 32'(samp[k]), 32'(SEG_3_N));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
